// File: rtl/mem_access_pkg.sv
// Shared types and encodings for the MEM-stage load/store unit.
// Covers FSM states, access-size decode and the funct3 zero-extend bit.
package mem_access_pkg;

  localparam int XLEN = 32;

  // funct3[2] selects zero-extension on loads (LBU/LHU)
  localparam int F3_UNSIGNED_BIT = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10
  } size_e;

  function automatic size_e access_size(input logic [1:0] f3_lo);
    case (f3_lo)
      2'b00:   return SZ_BYTE;
      2'b01:   return SZ_HALF;
      default: return SZ_WORD;
    endcase
  endfunction

endpackage

// File: rtl/mem_access_lsu_align.sv
// Combinational lane logic: store replication, byte enables, misalign
// detection for the incoming request, and extraction/extension of load data.
module mem_access_lsu_align
  import mem_access_pkg::*;
(
  input  logic [1:0]      st_size_i,
  input  logic [1:0]      st_off_i,
  input  logic [XLEN-1:0] sdata_i,
  input  logic [2:0]      ld_funct3_i,
  input  logic [1:0]      ld_off_i,
  input  logic [XLEN-1:0] rdata_i,
  output logic [XLEN-1:0] wdata_o,
  output logic [3:0]      be_o,
  output logic            misalign_o,
  output logic [XLEN-1:0] ldata_o
);

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic        ld_sext;

  always_comb begin
    wdata_o    = sdata_i;
    be_o       = 4'b1111;
    misalign_o = 1'b0;
    unique case (access_size(st_size_i))
      SZ_BYTE: begin
        wdata_o = {4{sdata_i[7:0]}};
        be_o    = 4'b0001 << st_off_i;
      end
      SZ_HALF: begin
        wdata_o    = {2{sdata_i[15:0]}};
        be_o       = st_off_i[1] ? 4'b1100 : 4'b0011;
        misalign_o = st_off_i[0];
      end
      default: misalign_o = |st_off_i;
    endcase
  end

  assign ld_byte = rdata_i[{ld_off_i, 3'b000} +: 8];
  assign ld_half = rdata_i[{ld_off_i[1], 4'b0000} +: 16];
  assign ld_sext = ~ld_funct3_i[F3_UNSIGNED_BIT];

  always_comb begin
    ldata_o = rdata_i;
    unique case (access_size(ld_funct3_i[1:0]))
      SZ_BYTE: ldata_o = {{24{ld_sext & ld_byte[7]}}, ld_byte};
      SZ_HALF: ldata_o = {{16{ld_sext & ld_half[15]}}, ld_half};
      default: ldata_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/mem_access.sv
// MEM-stage load/store unit: one single-beat valid/ack bus transaction per op,
// stalling the pipeline until the response (or a timeout) has been captured.
module mem_access
  import mem_access_pkg::*;
#(
  parameter int BITWIDTH = 32,
  parameter int TIMEOUT  = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ren,
  input  logic                wen,
  input  logic [2:0]          funct3,
  input  logic [BITWIDTH-1:0] addr,
  input  logic [BITWIDTH-1:0] sData,
  output logic [BITWIDTH-1:0] lData,
  output logic                stall,
  output logic                misalign,
  output logic                busErr,
  output logic                dReq,
  output logic                dWe,
  output logic [BITWIDTH-1:0] dAddr,
  output logic [BITWIDTH-1:0] dWdata,
  output logic [3:0]          dBe,
  input  logic [BITWIDTH-1:0] dRdata,
  input  logic                dAck
);

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d, cnt_inc;
  logic                timeout_hit;
  logic [BITWIDTH-1:0] ldata_q, ldata_d;
  logic                dreq_q, dreq_d;
  logic                dwe_q, dwe_d;
  logic [BITWIDTH-1:0] daddr_q, daddr_d;
  logic [BITWIDTH-1:0] dwdata_q, dwdata_d;
  logic [3:0]          dbe_q, dbe_d;
  logic                buserr_q, buserr_d;
  logic [2:0]          ld_funct3_q, ld_funct3_d;
  logic [1:0]          ld_off_q, ld_off_d;
  logic                is_load_q, is_load_d;

  logic [BITWIDTH-1:0] al_wdata;
  logic [3:0]          al_be;
  logic                al_misalign;
  logic [BITWIDTH-1:0] al_ldata;

  // Load extraction uses the op captured at launch, since the request
  // inputs are only guaranteed stable while the pipeline is frozen.
  mem_access_lsu_align u_align (
    .st_size_i   (funct3[1:0]),
    .st_off_i    (addr[1:0]),
    .sdata_i     (sData),
    .ld_funct3_i (ld_funct3_q),
    .ld_off_i    (ld_off_q),
    .rdata_i     (dRdata),
    .wdata_o     (al_wdata),
    .be_o        (al_be),
    .misalign_o  (al_misalign),
    .ldata_o     (al_ldata)
  );

  assign cnt_inc     = cnt_q + CNT_W'(1);
  assign timeout_hit = (TIMEOUT != 0) && (cnt_inc == CNT_W'(TIMEOUT));

  // NOTE: every signal written in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    ldata_d     = ldata_q;
    dreq_d      = dreq_q;
    dwe_d       = dwe_q;
    daddr_d     = daddr_q;
    dwdata_d    = dwdata_q;
    dbe_d       = dbe_q;
    buserr_d    = 1'b0;
    ld_funct3_d = ld_funct3_q;
    ld_off_d    = ld_off_q;
    is_load_d   = is_load_q;
    stall       = 1'b0;
    misalign    = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (ren || wen) begin
          if (al_misalign) begin
            misalign = 1'b1;
          end else begin
            stall       = 1'b1;
            state_d     = ST_REQ;
            cnt_d       = '0;
            dreq_d      = 1'b1;
            dwe_d       = wen;
            daddr_d     = {addr[BITWIDTH-1:2], 2'b00};
            dwdata_d    = al_wdata;
            dbe_d       = al_be;
            ld_funct3_d = funct3;
            ld_off_d    = addr[1:0];
            // a simultaneous store wins over the load
            is_load_d   = ~wen;
          end
        end
      end
      ST_REQ: begin
        stall = 1'b1;
        if (dAck) begin
          if (is_load_q) ldata_d = al_ldata;
          dreq_d  = 1'b0;
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_inc;
          if (timeout_hit) begin
            dreq_d   = 1'b0;
            buserr_d = 1'b1;
            ldata_d  = '0;
            state_d  = ST_DONE;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      ldata_q     <= '0;
      dreq_q      <= 1'b0;
      dwe_q       <= 1'b0;
      daddr_q     <= '0;
      dwdata_q    <= '0;
      dbe_q       <= '0;
      buserr_q    <= 1'b0;
      ld_funct3_q <= '0;
      ld_off_q    <= '0;
      is_load_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ldata_q     <= ldata_d;
      dreq_q      <= dreq_d;
      dwe_q       <= dwe_d;
      daddr_q     <= daddr_d;
      dwdata_q    <= dwdata_d;
      dbe_q       <= dbe_d;
      buserr_q    <= buserr_d;
      ld_funct3_q <= ld_funct3_d;
      ld_off_q    <= ld_off_d;
      is_load_q   <= is_load_d;
    end
  end

  assign lData  = ldata_q;
  assign busErr = buserr_q;
  assign dReq   = dreq_q;
  assign dWe    = dwe_q;
  assign dAddr  = daddr_q;
  assign dWdata = dwdata_q;
  assign dBe    = dbe_q;

endmodule

// File: tb/tb_mem_access.sv
// Scoreboard bench for mem_access: stimulus pushes expected bus/completion
// events computed from plain-arithmetic load/store rules; a monitor pops them.
module tb_mem_access;

  localparam int TMO = 8;

  logic        clk;
  logic        rst;
  logic        ren, wen;
  logic [2:0]  funct3;
  logic [31:0] addr, sData, lData;
  logic        stall, misalign, busErr;
  logic        dReq, dWe;
  logic [31:0] dAddr, dWdata, dRdata;
  logic [3:0]  dBe;
  logic        dAck;

  mem_access #(.BITWIDTH(32), .TIMEOUT(TMO)) dut (
    .clk      (clk),
    .rst      (rst),
    .ren      (ren),
    .wen      (wen),
    .funct3   (funct3),
    .addr     (addr),
    .sData    (sData),
    .lData    (lData),
    .stall    (stall),
    .misalign (misalign),
    .busErr   (busErr),
    .dReq     (dReq),
    .dWe      (dWe),
    .dAddr    (dAddr),
    .dWdata   (dWdata),
    .dBe      (dBe),
    .dRdata   (dRdata),
    .dAck     (dAck)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef enum {EV_BUS, EV_DONE, EV_MIS} ev_kind_e;
  typedef struct {
    ev_kind_e    kind;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [31:0] ldata;
    logic        buserr;
    int          stall_n;
    int          req_n;
  } ev_t;

  ev_t         exp_q[$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] model_ldata = 32'h0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: access size in bytes, extraction by shift/mask.
  function automatic int unsigned sz_bytes(input logic [2:0] f3);
    case (f3[1:0])
      2'b00:   return 1;
      2'b01:   return 2;
      default: return 4;
    endcase
  endfunction

  function automatic logic [31:0] ld_value(input logic [2:0] f3, input logic [31:0] a,
                                           input logic [31:0] rd);
    int unsigned n;
    logic [31:0] v;
    n = sz_bytes(f3);
    if (n == 4) return rd;
    v = (rd >> (8 * (a % 4))) & ((32'd1 << (8 * n)) - 32'd1);
    if (!f3[2] && v >= (32'd1 << (8 * n - 1))) v = v - (32'd1 << (8 * n));
    return v;
  endfunction

  function automatic ev_t bus_ev(input logic w, input logic [2:0] f3, input logic [31:0] a,
                                 input logic [31:0] sd);
    ev_t e;
    int unsigned n;
    n       = sz_bytes(f3);
    e.kind  = EV_BUS;
    e.we    = w;
    e.addr  = a & ~32'h3;
    e.wdata = (n == 1) ? {24'h0, sd[7:0]} * 32'h0101_0101 :
              (n == 2) ? {16'h0, sd[15:0]} * 32'h0001_0001 : sd;
    e.be    = 4'(((32'd1 << n) - 32'd1) << (a % 4));
    e.ldata = 32'h0;
    e.buserr = 1'b0;
    e.stall_n = 0;
    e.req_n = 0;
    return e;
  endfunction

  function automatic ev_t done_ev(input logic [31:0] ld, input logic be, input int nreq);
    ev_t e;
    e.kind    = EV_DONE;
    e.we      = 1'b0;
    e.addr    = 32'h0;
    e.wdata   = 32'h0;
    e.be      = 4'h0;
    e.ldata   = ld;
    e.buserr  = be;
    e.stall_n = nreq + 1;
    e.req_n   = nreq;
    return e;
  endfunction

  // delay = REQ cycle on which dAck is given (1 = immediate); 0 = never.
  task automatic do_op(input logic r, input logic w, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] sd,
                       input logic [31:0] rd, input int delay);
    ev_t e;
    int  k;
    int  nreq;
    bit  timed_out;
    if ((a % sz_bytes(f3)) != 0) begin
      e = done_ev(model_ldata, 1'b0, 0);
      e.kind = EV_MIS;
      exp_q.push_back(e);
      @(posedge clk); #1;
      ren = r; wen = w; funct3 = f3; addr = a; sData = sd; dAck = 1'b0;
      @(posedge clk); #1;
      ren = 1'b0; wen = 1'b0;
      return;
    end
    exp_q.push_back(bus_ev(w, f3, a, sd));
    timed_out = (delay == 0) || (delay > TMO);
    nreq      = timed_out ? TMO : delay;
    if (timed_out) model_ldata = 32'h0;
    else if (!w)   model_ldata = ld_value(f3, a, rd);
    exp_q.push_back(done_ev(model_ldata, timed_out, nreq));

    @(posedge clk); #1;
    ren = r; wen = w; funct3 = f3; addr = a; sData = sd; dAck = 1'b0;
    @(posedge clk); #1;
    k = 0;
    while (dReq === 1'b1 && k < 40) begin
      k++;
      dAck   = (k == delay);
      dRdata = (k == delay) ? rd : $urandom;
      @(posedge clk); #1;
    end
    // DONE: request inputs still held, stray acks must be ignored
    dAck   = 1'($urandom_range(0, 1));
    dRdata = $urandom;
    @(posedge clk); #1;
    ren = 1'b0; wen = 1'b0; dAck = 1'b0;
  endtask

  task automatic pop_ev(input ev_kind_e k, output ev_t e, output bit ok);
    ok = 1'b0;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL event_%s: got unexpected event, expected none pending", k.name());
    end else if (exp_q[0].kind != k) begin
      errors++;
      $display("FAIL event_order: got %s expected %s", k.name(), exp_q[0].kind.name());
      e = exp_q.pop_front();
    end else begin
      e  = exp_q.pop_front();
      ok = 1'b1;
    end
  endtask

  // Monitor
  ev_t mon_e;
  ev_t bus_exp;
  bit  mon_ok;
  bit  bus_valid  = 1'b0;
  bit  dreq_prev  = 1'b0;
  bit  stall_prev = 1'b0;
  bit  berr_prev  = 1'b0;
  int  stall_cnt  = 0;
  int  req_cnt    = 0;

  always @(negedge clk) begin
    if (misalign === 1'b1) begin
      pop_ev(EV_MIS, mon_e, mon_ok);
      if (mon_ok) begin
        check("mis_stall", 32'(stall), 32'h0);
        check("mis_ldata", lData, mon_e.ldata);
      end
    end
    if (dReq === 1'b1 && !dreq_prev) begin
      pop_ev(EV_BUS, bus_exp, bus_valid);
      req_cnt = 0;
      if (bus_valid) begin
        check("bus_we", 32'(dWe), 32'(bus_exp.we));
        check("bus_addr", dAddr, bus_exp.addr);
        check("bus_wdata", dWdata, bus_exp.wdata);
        check("bus_be", 32'(dBe), 32'(bus_exp.be));
      end
    end else if (dReq === 1'b1 && bus_valid) begin
      check("hold_addr", dAddr, bus_exp.addr);
      check("hold_wdata", dWdata, bus_exp.wdata);
      check("hold_ctl", 32'({dWe, dBe}), 32'({bus_exp.we, bus_exp.be}));
    end
    if (dReq === 1'b1) req_cnt++;
    if (stall === 1'b1) stall_cnt++;
    if (berr_prev) check("buserr_pulse", 32'(busErr), 32'h0);
    if (stall === 1'b0 && stall_prev) begin
      pop_ev(EV_DONE, mon_e, mon_ok);
      if (mon_ok) begin
        check("done_ldata", lData, mon_e.ldata);
        check("done_buserr", 32'(busErr), 32'(mon_e.buserr));
        check("stall_cycles", stall_cnt, mon_e.stall_n);
        check("req_cycles", req_cnt, mon_e.req_n);
      end
      stall_cnt = 0;
      req_cnt   = 0;
      bus_valid = 1'b0;
    end
    dreq_prev  = (dReq === 1'b1);
    stall_prev = (stall === 1'b1);
    berr_prev  = (busErr === 1'b1);
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish by 500000, expected earlier finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; ren = 1'b0; wen = 1'b0; funct3 = 3'b000;
    addr = 32'h0; sData = 32'h0; dRdata = 32'h0; dAck = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ldata", lData, 32'h0);
    check("rst_dreq", 32'(dReq), 32'h0);
    check("rst_dwe", 32'(dWe), 32'h0);
    check("rst_daddr", dAddr, 32'h0);
    check("rst_dwdata", dWdata, 32'h0);
    check("rst_dbe", 32'(dBe), 32'h0);
    check("rst_buserr", 32'(busErr), 32'h0);
    check("rst_stall", 32'(stall), 32'h0);
    check("rst_misalign", 32'(misalign), 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;

    do_op(1'b1, 1'b0, 3'b010, 32'h0000_1000, 32'h0, 32'hDEAD_BEEF, 3);   // LW
    do_op(1'b1, 1'b0, 3'b000, 32'h0000_1003, 32'h0, 32'h80FF_1234, 1);   // LB
    do_op(1'b1, 1'b0, 3'b100, 32'h0000_1003, 32'h0, 32'h80FF_1234, 1);   // LBU
    do_op(1'b1, 1'b0, 3'b001, 32'h0000_1002, 32'h0, 32'h80FF_1234, 1);   // LH
    do_op(1'b1, 1'b0, 3'b101, 32'h0000_1002, 32'h0, 32'h80FF_1234, 1);   // LHU
    do_op(1'b0, 1'b1, 3'b000, 32'h0000_2001, 32'h0000_00AB, $urandom, 1); // SB
    do_op(1'b0, 1'b1, 3'b001, 32'h0000_2002, 32'h0000_1234, $urandom, 1); // SH
    do_op(1'b1, 1'b0, 3'b010, 32'h0000_1002, 32'h0, 32'h1111_1111, 1);   // misaligned LW
    do_op(1'b0, 1'b1, 3'b001, 32'h0000_2001, 32'h5555_6666, 32'h0, 1);   // misaligned SH
    do_op(1'b1, 1'b0, 3'b010, 32'h0000_1000, 32'h0, 32'h0, 0);           // timeout
    do_op(1'b1, 1'b0, 3'b010, 32'h0000_1004, 32'h0, 32'h7777_8888, TMO); // ack on last cycle
    do_op(1'b1, 1'b1, 3'b010, 32'h0000_4000, 32'h55AA_55AA, 32'h1234_5678, 2); // store wins

    for (int i = 0; i < 60; i++) begin
      int unsigned kind;
      logic [2:0]  f3;
      logic [31:0] a;
      kind = $urandom_range(0, 2);
      f3   = 3'($urandom_range(0, 7));
      a    = $urandom;
      if ($urandom_range(0, 3) != 0) a = a & ~32'(sz_bytes(f3) - 1);
      do_op(kind != 1, kind != 0, f3, a, $urandom, $urandom, int'($urandom_range(0, 10)));
    end

    // Reset in the second REQ cycle of a load that is never acked
    do_op(1'b1, 1'b0, 3'b010, 32'h0000_5000, 32'h0, 32'hCAFE_F00D, 1);
    exp_q.push_back(bus_ev(1'b0, 3'b010, 32'h0000_3000, 32'h0));
    model_ldata = 32'h0;
    exp_q.push_back(done_ev(32'h0, 1'b0, 2));
    @(posedge clk); #1;
    ren = 1'b1; wen = 1'b0; funct3 = 3'b010; addr = 32'h0000_3000; sData = 32'h0; dAck = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; ren = 1'b0;
    @(negedge clk);
    check("midrst_dreq", 32'(dReq), 32'h0);
    check("midrst_stall", 32'(stall), 32'h0);
    repeat (3) begin
      @(posedge clk); #1;
      dAck = 1'b1; dRdata = $urandom;
    end
    @(posedge clk); #1;
    dAck = 1'b0;
    @(negedge clk);
    check("late_ack_ldata", lData, 32'h0);
    check("late_ack_dreq", 32'(dReq), 32'h0);
    check("late_ack_stall", 32'(stall), 32'h0);
    check("late_ack_buserr", 32'(busErr), 32'h0);

    repeat (3) @(posedge clk);
    check("pending_events", exp_q.size(), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_access.md
Name: mem_access

Overview:
- Load/store unit of the MEM stage, between the EX/MEM pipeline register and mem_wb.
- Takes the ALU result as the address, runs one single-beat valid/ack transaction on the data bus, and aligns store data and byte strobes.
- Extracts and sign/zero-extends load data, which goes to mem_wb lData.
- Holds stall high while a transaction is outstanding, so upstream stages freeze.

Parameters:
- BITWIDTH, 32, datapath/address width; only 32 is supported.
- TIMEOUT, 16, maximum REQ cycles without dAck before bus error; 0 disables the timeout.

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- ren  in  1  load request from EX/MEM
- wen  in  1  store request from EX/MEM
- funct3  in  3  RV32I load/store funct3
- addr  in  BITWIDTH  effective address (ALU result)
- sData  in  BITWIDTH  store data (rs2)
- lData  out  BITWIDTH  extended load data to mem_wb
- stall  out  1  freeze PC/IF/ID/EX/MEM registers
- misalign  out  1  misaligned access, for the trap logic
- busErr  out  1  one-cycle pulse on bus timeout
- dReq  out  1  bus request, registered
- dWe  out  1  bus write enable, registered
- dAddr  out  BITWIDTH  word-aligned bus address ({addr[31:2],2'b00}), registered
- dWdata  out  BITWIDTH  lane-replicated store data, registered
- dBe  out  4  byte enables, registered
- dRdata  in  BITWIDTH  bus read data
- dAck  in  1  bus acknowledge; data valid in the same cycle

Behaviour:
- Reset: the synchronous, active-high rst forces state IDLE and counter 0, and sets lData, dReq, dWe, dAddr, dWdata, dBe, busErr to 0. stall and misalign are 0 while in IDLE with no request.
- FSM states: IDLE, REQ, DONE.
- IDLE, valid aligned request (ren|wen):
  - stall=1 combinationally.
  - At the edge: register dReq=1, dWe=wen, dAddr, dWdata, dBe; go to REQ.
  - ren&wen both high: the store is performed and the load is ignored.
- IDLE, misaligned request: misalign=1 combinationally, no transaction, stall=0, stay IDLE.
  - Half access is misaligned when addr[0]=1.
  - Word access is misaligned when addr[1:0]!=0.
- REQ:
  - stall=1, dReq held, bus outputs stable.
  - On dAck=1: if it is a load, lData<=extracted dRdata. Then dReq<=0, go to DONE.
  - Otherwise the counter increments. If the counter reaches TIMEOUT (TIMEOUT>0): dReq<=0, busErr<=1, lData<=0, go to DONE.
- DONE:
  - Lasts exactly one cycle; stall=0 so the pipeline advances and mem_wb captures lData.
  - Inputs are ignored (they still carry the finished op); busErr clears; go to IDLE.
- Latency: minimum 3 cycles per memory op (IDLE, REQ with dAck, DONE). stall high for 1+N cycles, where N = number of REQ cycles.
- dAck outside REQ is ignored. lData is unchanged by stores and by misaligned ops.
- Access size uses funct3[1:0]: 00 byte, 01 half, 10/11 word. funct3[2]=1 means zero-extend (loads only).
- Load extraction:
  - byte = dRdata[8*addr[1:0] +: 8]
  - half = dRdata[16*addr[1] +: 16]
  - Sign-extend unless funct3[2]=1.
- Store alignment:
  - SB: dWdata={4{sData[7:0]}}, dBe=4'b0001<<addr[1:0].
  - SH: dWdata={2{sData[15:0]}}, dBe = addr[1] ? 1100 : 0011.
  - SW: dWdata=sData, dBe=1111.
  - Loads drive the same dBe mask.
- Reset mid-transaction: dReq drops at that edge, the transaction is abandoned, and a later dAck is ignored.

Decomposition:
- defines.v (shared): BITWIDTH, RESET, funct3 size/sign encodings, FSM state encodings.
- One combinational sub-module, lsu_align: store lane replication, byte-enable generation, load extract/extend, misalign detect.
- mem_access holds the FSM, timeout counter and output registers.

Test Plan:
- LW addr 0x1000, dAck on 3rd REQ cycle, dRdata 0xDEADBEEF -> dAddr 0x1000, dBe 1111, dWe 0, dReq high 3 cycles, stall high 4 cycles, lData 0xDEADBEEF in DONE.
- dRdata 0x80FF1234 with immediate dAck:
  - LB 0x1003 -> lData 0xFFFFFF80
  - LBU 0x1003 -> 0x00000080
  - LH 0x1002 -> 0xFFFF80FF
  - LHU 0x1002 -> 0x000080FF
- Stores:
  - SB 0x2001, sData 0xAB -> dAddr 0x2000, dWdata 0xABABABAB, dBe 0010, dWe 1.
  - SH 0x2002, sData 0x1234 -> dWdata 0x12341234, dBe 1100.
  - lData unchanged.
- LW 0x1002 -> misalign 1 same cycle, stall 0, dReq never rises, lData unchanged. SH 0x2001 -> misalign 1.
- TIMEOUT=8, dAck held 0 -> dReq high exactly 8 cycles, busErr 1 for one cycle in DONE, lData 0, stall 0 in DONE.
- rst high during 2nd REQ cycle -> next cycle dReq 0, stall 0, lData 0, state IDLE. A subsequent dAck=1 causes no change.
